// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
package adder_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned slice_count(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder4.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module carry_lookahead_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // Every carry is flattened from c_in so no carry ripples through the slice.
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum  = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder16.sv
// Multi-cycle adder: pushes one nibble per clock through a single CLA slice,
// LSB first, carrying the slice carry-out between cycles.
module nibble_serial_adder16
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CO
);

  localparam int unsigned NIBBLES = slice_count(WIDTH);
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   psum;
  logic [WIDTH-1:0]   psum_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_co;

  carry_lookahead_adder4 u_slice (
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .c_in (carry),
    .sum  (slice_sum),
    .co   (slice_co)
  );

  // Each slice result enters at the top, so after NIBBLES passes the
  // first nibble has walked down to bit 0.
  always_comb begin
    psum_next = psum >> SLICE_W;
    psum_next[WIDTH-1 -: SLICE_W] = slice_sum;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      CO    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= C_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= slice_co;
          psum  <= psum_next;
          a_sh  <= a_sh >> SLICE_W;
          b_sh  <= b_sh >> SLICE_W;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum   <= psum_next;
            CO    <= slice_co;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Scoreboard bench for nibble_serial_adder16: stimulus queues expected results,
// a negedge monitor checks them whenever Done is presented.
module tb_nibble_serial_adder16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        C_in = 1'b0;
  logic        Busy;
  logic        Done;
  logic [15:0] Sum;
  logic        CO;

  nibble_serial_adder16 #(.WIDTH(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .C_in    (C_in),
    .Busy    (Busy),
    .Done    (Done),
    .Sum     (Sum),
    .CO      (CO)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    int unsigned at;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done cycle must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Done !== 1'b0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=%b Sum=%0h expected no Done (cycle %0d)", Done, Sum, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum", 32'(Sum), 32'(e.sum));
        check("co", 32'(CO), 32'(e.co));
        check("done_cycle", cyc, e.at);
      end
    end
  end

  // Present one operand while idle; Done is due 4 edges after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic eco);
    @(negedge Clk);
    A = a;
    B = b;
    C_in = ci;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    sb_q.push_back('{sum: es, co: eco, at: cyc + 4});
    Start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      #1;
      if (sb_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got %0d pending results expected 0", sb_q.size());
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int unsigned k;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_sum", 32'(Sum), 32'h0);
    check("rst_co", 32'(CO), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Basic add, with Busy width measured
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    busy_cnt = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd5);
    wait_done();

    // Inter-nibble carry and carry-in paths
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1); wait_done();
    issue(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0); wait_done();
    issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1); wait_done();
    issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0); wait_done();
    issue(16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1); wait_done();

    // Start and operand changes while busy are ignored
    issue(16'h00FF, 16'h0F0F, 1'b0, 16'h100E, 1'b0);
    @(negedge Clk);
    A = 16'hAAAA;
    B = 16'h5555;
    C_in = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    wait_done();
    repeat (3) @(negedge Clk);
    check("hold_sum", 32'(Sum), 32'h100E);
    check("hold_co", 32'(CO), 32'h0);

    // Reset abort in the second RUN cycle
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_done", 32'(Done), 32'h0);
    check("abort_sum", 32'(Sum), 32'h0);
    check("abort_co", 32'(CO), 32'h0);
    repeat (6) @(negedge Clk);
    Reset_n = 1'b1;
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    wait_done();

    // Back-to-back with Start held high: accepts 6 edges apart
    @(negedge Clk);
    A = 16'h0001;
    B = 16'h0001;
    C_in = 1'b0;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    k = cyc;
    sb_q.push_back('{sum: 16'h0002, co: 1'b0, at: k + 4});
    A = 16'h7FFF;
    B = 16'h0001;
    repeat (6) @(posedge Clk);
    #1;
    sb_q.push_back('{sum: 16'h8000, co: 1'b0, at: k + 10});
    Start = 1'b0;
    check("b2b_busy", 32'(Busy), 32'h1);
    repeat (4) begin
      @(negedge Clk);
      check("b2b_sum_stable", 32'(Sum), 32'h0002);
    end
    wait_done();
    repeat (3) @(negedge Clk);
    check("b2b_final_sum", 32'(Sum), 32'h8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
